// File: rtl/sigmoid_arbiter_pkg.sv
// Shared types and helpers for the sigmoid arbiter slice: FSM encoding, default widths and
// requester-ID width calculation.
package sigmoid_arb_pkg;

    localparam int unsigned DefDataWidth  = 32;
    localparam int unsigned DefSigLatency = 4;

    typedef enum logic [0:0] {
        StArb,
        StGap
    } arb_state_e;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sigmoid_arbiter_if.sv
// Requester, sigmoid-datapath and response signals of the sigmoid arbiter, bundled with
// master (arbiter side) and slave (environment side) modports.
interface sigmoid_arbiter_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]       sig_in;
    logic                        sig_in_valid;
    logic [DATA_WIDTH-1:0]       sig_out;
    logic [N_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]       rsp_data;
    logic                        busy;

    modport master (
        input  req_valid, req_data, sig_out,
        output req_ready, sig_in, sig_in_valid, rsp_valid, rsp_data, busy
    );

    modport slave (
        output req_valid, req_data, sig_out,
        input  req_ready, sig_in, sig_in_valid, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/sigmoid_arbiter_rr_arbiter.sv
// Round-robin priority search over N_REQ requests: one-hot grant plus encoded index; the
// pointer moves to the granted index only when the grant is accepted.
module rr_arbiter
    import sigmoid_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IdW   = id_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] grant,
    output logic [IdW-1:0]   grant_id,
    output logic             grant_valid
);

    logic [IdW-1:0] ptr_q;

    // Search starts just after the last granted requester and wraps.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            int unsigned idx;
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = IdW'(idx);
                grant[idx]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IdW'(N_REQ - 1);
        end else if (accept && grant_valid) begin
            ptr_q <= grant_id;
        end
    end

endmodule

// File: rtl/sigmoid_arbiter.sv
// Shares one fixed-latency sigmoid unit between N_REQ requesters with round-robin arbitration,
// minimum issue spacing and ID-tagged result routing. SIGMOID_ARBITER_PERF_EN adds counters.
module sigmoid_arbiter
    import sigmoid_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned SIG_LATENCY = DefSigLatency,
    parameter int unsigned ISSUE_GAP   = 1
) (
    input  logic               clk,
    input  logic               rst,
    sigmoid_arbiter_if.master  bus
`ifdef SIGMOID_ARBITER_PERF_EN
    ,
    output logic [31:0]        perf_issue_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    localparam int unsigned IdW  = id_width(N_REQ);
    localparam int unsigned GapW = $clog2(ISSUE_GAP + 1);

    arb_state_e state_q, state_d;
    logic [GapW-1:0] gap_q, gap_d;

    logic [N_REQ-1:0] grant;
    logic [IdW-1:0]   grant_id;
    logic             grant_valid;
    logic             arb_en;
    logic             accept;
    logic [DATA_WIDTH-1:0] operand;

    logic                  sig_in_valid_q;
    logic [DATA_WIDTH-1:0] sig_in_q;
    logic [IdW-1:0]        issue_id_q;

    logic [SIG_LATENCY-1:0] tag_vld_q;
    logic [IdW-1:0]         tag_id_q [SIG_LATENCY];

    logic [N_REQ-1:0]      rsp_onehot;
    logic [N_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req         (bus.req_valid),
        .accept      (accept),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign arb_en        = (state_q == StArb);
    assign accept        = arb_en && grant_valid;
    assign bus.req_ready = arb_en ? grant : '0;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            StArb: begin
                if (accept && (ISSUE_GAP > 1)) begin
                    state_d = StGap;
                    gap_d   = GapW'(ISSUE_GAP - 1);
                end
            end
            StGap: begin
                if (gap_q <= GapW'(1)) begin
                    state_d = StArb;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: begin
                state_d = StArb;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StArb;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Grant is one-hot, so an OR-reduction selects the winning operand.
    always_comb begin
        operand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                operand = operand | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_in_valid_q <= 1'b0;
            sig_in_q       <= '0;
            issue_id_q     <= '0;
        end else begin
            sig_in_valid_q <= accept;
            if (accept) begin
                sig_in_q   <= operand;
                issue_id_q <= grant_id;
            end
        end
    end

    // Tags travel alongside the datapath so the last stage lines up with sig_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q <= '0;
            for (int i = 0; i < SIG_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0] <= sig_in_valid_q;
            tag_id_q[0]  <= issue_id_q;
            for (int i = 1; i < SIG_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    always_comb begin
        rsp_onehot = '0;
        rsp_onehot[tag_id_q[SIG_LATENCY-1]] = tag_vld_q[SIG_LATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_onehot;
            if (tag_vld_q[SIG_LATENCY-1]) begin
                rsp_data_q <= bus.sig_out;
            end
        end
    end

    assign bus.sig_in       = sig_in_q;
    assign bus.sig_in_valid = sig_in_valid_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.busy         = (state_q == StGap) || sig_in_valid_q || (|tag_vld_q)
                              || (|rsp_valid_q);

`ifdef SIGMOID_ARBITER_PERF_EN
    logic [31:0] perf_issue_q;
    logic [31:0] perf_stall_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (accept && (perf_issue_q != '1)) begin
                perf_issue_q <= perf_issue_q + 32'd1;
            end
            if ((|bus.req_valid) && !accept && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Bench for sigmoid_arbiter: two instances (issue gap 1 and 3) run against a cycle-indexed
// reference of grants, issues and responses, with directed steps and random requesters.
module tb_sigmoid_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned L  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sigmoid_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus_a ();
    sigmoid_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus_b ();

`ifdef SIGMOID_ARBITER_PERF_EN
    logic [31:0] pi_a, ps_a, pi_b, ps_b;
`endif

    sigmoid_arbiter #(
        .DATA_WIDTH (DW), .N_REQ (N), .SIG_LATENCY (L), .ISSUE_GAP (1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
`ifdef SIGMOID_ARBITER_PERF_EN
        , .perf_issue_cnt (pi_a), .perf_stall_cnt (ps_a)
`endif
    );

    sigmoid_arbiter #(
        .DATA_WIDTH (DW), .N_REQ (N), .SIG_LATENCY (L), .ISSUE_GAP (3)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
`ifdef SIGMOID_ARBITER_PERF_EN
        , .perf_issue_cnt (pi_b), .perf_stall_cnt (ps_b)
`endif
    );

    // Stand-in sigmoid unit: arbitrary bijection with a fixed latency of L cycles.
    function automatic logic [DW-1:0] sig_fn(input logic [DW-1:0] x);
        return {x[15:0] ^ 16'hBEEF, x[31:16]} + 32'h0000_1001;
    endfunction

    logic [DW-1:0] pipe_a [L];
    logic [DW-1:0] pipe_b [L];
    always @(posedge clk) begin
        pipe_a[0] <= sig_fn(bus_a.sig_in);
        pipe_b[0] <= sig_fn(bus_b.sig_in);
        for (int i = 1; i < L; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign bus_a.sig_out = pipe_a[L-1];
    assign bus_b.sig_out = pipe_b[L-1];

    typedef struct {
        int unsigned   cyc;
        int            id;
        logic [DW-1:0] data;
    } ev_t;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned cyc    = 0;
    int          cur    = 0;
    int unsigned gap    = 1;
    bit [N-1:0]  pend   = '0;
    logic [DW-1:0] pdata [N];
    int          ptr        = N - 1;
    bit          have_grant = 1'b0;
    int unsigned last_g     = 0;
    int unsigned m_iss      = 0;
    int unsigned m_stall    = 0;
    ev_t iss_q[$];
    ev_t rsp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        iss_q.delete();
        rsp_q.delete();
        ptr        = N - 1;
        have_grant = 1'b0;
        m_iss      = 0;
        m_stall    = 0;
    endtask

    // One clock of stimulus, comparison against the reference, and reference update.
    task automatic step(input bit do_rst, input bit [N-1:0] raise, input bit rnd);
        logic [N*DW-1:0] vec;
        logic [N-1:0]    o_rdy, o_rv, exp_rdy, oh;
        logic [DW-1:0]   o_si, o_rd;
        logic            o_siv, o_busy;
        int              gid;
        bit              grant;
        int unsigned     span;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (rnd) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = $urandom;
                end else if (pend[i] && $urandom_range(15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            if (raise[i] && !pend[i]) begin
                pend[i]  = 1'b1;
                pdata[i] = $urandom;
            end
        end
        if (do_rst) pend = '0;
        rst = do_rst;
        for (int i = 0; i < N; i++) vec[i*DW +: DW] = pdata[i];
        if (cur == 0) begin
            bus_a.req_valid = pend;  bus_a.req_data = vec;
            bus_b.req_valid = '0;    bus_b.req_data = '0;
        end else begin
            bus_b.req_valid = pend;  bus_b.req_data = vec;
            bus_a.req_valid = '0;    bus_a.req_data = '0;
        end
        #1;
        if (cur == 0) begin
            o_rdy = bus_a.req_ready; o_si = bus_a.sig_in; o_siv = bus_a.sig_in_valid;
            o_rv = bus_a.rsp_valid;  o_rd = bus_a.rsp_data; o_busy = bus_a.busy;
        end else begin
            o_rdy = bus_b.req_ready; o_si = bus_b.sig_in; o_siv = bus_b.sig_in_valid;
            o_rv = bus_b.rsp_valid;  o_rd = bus_b.rsp_data; o_busy = bus_b.busy;
        end

        grant = 1'b0;
        gid   = 0;
        if (pend != '0 && (!have_grant || (cyc - last_g) >= gap)) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (!grant && pend[idx]) begin
                    grant = 1'b1;
                    gid   = idx;
                end
            end
        end
        exp_rdy = '0;
        if (grant) exp_rdy[gid] = 1'b1;
        check("req_ready", 64'(o_rdy), 64'(exp_rdy));

        if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
            check("sig_in_valid", 64'(o_siv), 64'd1);
            check("sig_in", 64'(o_si), 64'(iss_q[0].data));
            void'(iss_q.pop_front());
        end else begin
            check("sig_in_valid", 64'(o_siv), 64'd0);
        end

        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
            oh = '0;
            oh[rsp_q[0].id] = 1'b1;
            check("rsp_valid", 64'(o_rv), 64'(oh));
            check("rsp_data", 64'(o_rd), 64'(rsp_q[0].data));
            void'(rsp_q.pop_front());
        end else begin
            check("rsp_valid", 64'(o_rv), 64'd0);
        end

        span = (L + 2 > gap - 1) ? L + 2 : gap - 1;
        check("busy", 64'(o_busy),
              64'(have_grant && cyc > last_g && (cyc - last_g) <= span));

`ifdef SIGMOID_ARBITER_PERF_EN
        check("perf_issue_cnt", 64'((cur == 0) ? pi_a : pi_b), 64'(m_iss));
        check("perf_stall_cnt", 64'((cur == 0) ? ps_a : ps_b), 64'(m_stall));
`endif

        if (grant) begin
            pend[gid] = 1'b0;
            iss_q.push_back('{cyc: cyc + 1, id: gid, data: pdata[gid]});
            rsp_q.push_back('{cyc: cyc + 2 + L, id: gid, data: sig_fn(pdata[gid])});
            ptr        = gid;
            have_grant = 1'b1;
            last_g     = cyc;
            m_iss++;
        end else if (pend != '0) begin
            m_stall++;
        end
        if (do_rst) model_reset();
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) pdata[i] = '0;

        // Instance with back-to-back issue.
        cur = 0; gap = 1;
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        #1;
        check("rst_sig_in", 64'(bus_a.sig_in), 64'd0);
        check("rst_rsp_data", 64'(bus_a.rsp_data), 64'd0);
        check("rst_busy", 64'(bus_a.busy), 64'd0);

        pend[0] = 1'b1; pdata[0] = 32'h3F80_0000;
        step(1'b0, '0, 1'b0);
        idle(8);

        for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, 1'b0);
        idle(10);

        // Grants to 2 then 3, then reset while both are in flight.
        pend[1] = 1'b1; pdata[1] = $urandom;
        step(1'b0, '0, 1'b0);
        step(1'b0, 4'b1100, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        idle(3);
        pend[3] = 1'b1; pdata[3] = $urandom;
        step(1'b0, '0, 1'b0);
        idle(8);

        for (int i = 0; i < 150; i++) step(1'b0, '0, 1'b1);
        idle(10);

        // Instance with an issue gap of three cycles.
        cur = 1; gap = 3; pend = '0;
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 4'b0011, 1'b0);
        idle(10);

        // Requester 1 withdraws during the gap; requester 2 must win afterwards.
        pend[0] = 1'b1; pdata[0] = $urandom;
        step(1'b0, '0, 1'b0);
        step(1'b0, 4'b0110, 1'b0);
        pend[1] = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        idle(10);

        for (int i = 0; i < 150; i++) step(1'b0, '0, 1'b1);
        idle(10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
